// File: rtl/aes_stream_arbiter.sv
// Round-robin N-to-1 arbiter feeding one AES encrypter stream, with burst-held grants and a tagged registered output.
// Optional macro AES_STREAM_ARB_FIXED_PRIO_EN: the idle search becomes fixed priority (lowest index wins).
//
// state | meaning
// IDLE  | no grant held; pick the next requester with valid high (one cycle per burst)
// GRANT | grant held; forward beats from the granted requester until BURST_LEN or source idle
module aes_stream_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int BURST_LEN = 4,
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_REQ*DATA_WIDTH_IN_BYTES*8-1:0]   in_data,
  input  logic [NUM_REQ-1:0]                         in_valid,
  output logic [NUM_REQ-1:0]                         in_rdy,
  output logic [DATA_WIDTH_IN_BYTES*8-1:0]           out_data,
  output logic                                       out_valid,
  input  logic                                       out_rdy,
  output logic [SRC_W-1:0]                           out_src_id
);

  localparam int DW = DATA_WIDTH_IN_BYTES * 8;
  localparam int NPAD = 1 << SRC_W;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] last_grant_q, last_grant_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SRC_W-1:0] out_src_id_q, out_src_id_d;

  logic             can_load;
  logic             xfer;
  logic             gnt_valid;
  logic             found;
  logic [SRC_W-1:0] pick_idx;
  logic [NPAD-1:0]  valid_pad;
  logic [DW-1:0]    sel_data;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_src_id_d = out_src_id_q;

    can_load  = !out_valid_q || out_rdy;
    valid_pad = '0;
    valid_pad[NUM_REQ-1:0] = in_valid;
    gnt_valid = valid_pad[grant_q];

    sel_data = '0;
    in_rdy   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == SRC_W'(i)) begin
        sel_data  = in_data[i*DW +: DW];
        in_rdy[i] = (state_q == GRANT) && can_load;
      end
    end
    xfer = (state_q == GRANT) && can_load && gnt_valid;

    // Scan from the far end so the last hit is the highest-priority candidate.
    found    = 1'b0;
    pick_idx = '0;
`ifdef AES_STREAM_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        found    = 1'b1;
        pick_idx = SRC_W'(i);
      end
    end
`else
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (valid_pad[SRC_W'((int'(last_grant_q) + i) % NUM_REQ)]) begin
        found    = 1'b1;
        pick_idx = SRC_W'((int'(last_grant_q) + i) % NUM_REQ);
      end
    end
`endif

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d      = pick_idx;
          last_grant_d = pick_idx;
          beat_cnt_d   = '0;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_cnt_d == 8'(BURST_LEN)) state_d = IDLE;
        end else if (can_load) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new beat replaces the old one in the same cycle it drains, so no bubble.
    if (xfer) begin
      out_data_d   = sel_data;
      out_src_id_d = grant_q;
      out_valid_d  = 1'b1;
    end else if (out_rdy) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_src_id_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_src_id_q <= out_src_id_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_src_id = out_src_id_q;

endmodule

// File: tb/tb_aes_stream_arbiter.sv
// Directed bench for aes_stream_arbiter (3 requesters, bursts of 4) with an expected-beat queue.
module tb_aes_stream_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DW      = 128;
  localparam int BURST   = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ*DW-1:0]   in_data;
  logic [NUM_REQ-1:0]      in_valid;
  logic [NUM_REQ-1:0]      in_rdy;
  logic [DW-1:0]           out_data;
  logic                    out_valid;
  logic                    out_rdy;
  logic [1:0]              out_src_id;

  aes_stream_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_WIDTH_IN_BYTES(16),
    .BURST_LEN(BURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_rdy(in_rdy),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_rdy(out_rdy),
    .out_src_id(out_src_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cnt[NUM_REQ];
  int   lim[NUM_REQ];

  function automatic logic [DW-1:0] make_data(input int src, input int k);
    logic [DW-1:0] d;
    d = '0;
    d[127:120] = 8'(src);
    d[119:88]  = 32'hC0DE0000 ^ 32'(k * 7);
    d[31:0]    = 32'(k);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int src, input int first, input int n);
    for (int k = 0; k < n; k++) q.push_back(exp_t'{src: 2'(src), data: make_data(src, first + k)});
  endtask

  task automatic drive_data();
    for (int i = 0; i < NUM_REQ; i++) in_data[i*DW +: DW] = make_data(i, cnt[i]);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    assert (q.size() > 0) else begin
      errors++;
      $error("FAIL unexpected_beat: observed=%0h expected=none", out_data);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("out_data", out_data, e.data);
      chk("out_src_id", 128'(out_src_id), 128'(e.src));
    end
  endtask

  // One clock: sample handshakes at the falling edge, advance sources just after the rising edge.
  task automatic step();
    logic [NUM_REQ-1:0] fire;
    @(negedge clk);
    if (out_valid && out_rdy) check_out();
    fire = in_valid & in_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (fire[i]) cnt[i]++;
      if (cnt[i] >= lim[i]) in_valid[i] = 1'b0;
    end
    drive_data();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 128'(q.size()), 128'(0));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = '0;
    out_rdy  = 1'b0;
    step();
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt[i] = 0;
      lim[i] = 1000;
    end
    drive_data();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    chk("rst_out_src_id", 128'(out_src_id), 128'(0));
    chk("rst_in_rdy", 128'(in_rdy), 128'(0));
  endtask

  initial begin
    logic [9:0] pat1;
    logic [7:0] pat4;
    int last;

    for (int i = 0; i < NUM_REQ; i++) begin
      cnt[i] = 0;
      lim[i] = 1000;
    end
    in_valid = '0;
    out_rdy  = 1'b0;
    rst      = 1'b1;
    drive_data();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single requester, 6 beats: 4, one idle cycle, 2.
    out_rdy  = 1'b1;
    lim[0]   = 6;
    push(0, 0, 6);
    in_valid = 3'b001;
    pat1     = 10'b0110111100;
    last     = -1;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("t1_out_valid_c%0d", c), 128'(out_valid), 128'(pat1[c]));
      if (out_valid) last = c;
      step();
    end
    chk("t1_last_out_cycle", 128'(last), 128'(8));
    chk("t1_queue_empty", 128'(q.size()), 128'(0));

    // All three continuously valid, 8 beats each.
    do_reset();
    out_rdy = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) lim[i] = 8;
`ifdef AES_STREAM_ARB_FIXED_PRIO_EN
    push(0, 0, 8);
    push(1, 0, 8);
    push(2, 0, 8);
`else
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < NUM_REQ; s++) push(s, r * BURST, BURST);
`endif
    in_valid = 3'b111;
    drain("t2_drain", 100);

    // Backpressure 1,0,0,1 during a burst.
    do_reset();
    out_rdy  = 1'b1;
    lim[0]   = 4;
    push(0, 0, 4);
    in_valid = 3'b001;
    step();
    step();
    step();
    out_rdy = 1'b0;
    #1;
    chk("t3_stall1_valid", 128'(out_valid), 128'(1));
    chk("t3_stall1_data", out_data, make_data(0, 1));
    chk("t3_stall1_in_rdy", 128'(in_rdy), 128'(0));
    step();
    #1;
    chk("t3_stall2_valid", 128'(out_valid), 128'(1));
    chk("t3_stall2_data", out_data, make_data(0, 1));
    chk("t3_stall2_in_rdy", 128'(in_rdy), 128'(0));
    step();
    out_rdy = 1'b1;
    #1;
    chk("t3_resume_in_rdy", 128'(in_rdy), 128'(3'b001));
    drain("t3_drain", 20);
    chk("t3_req0_beats", 128'(cnt[0]), 128'(4));

    // Early release: req1 stops after 2 beats, req0 waiting.
    do_reset();
    out_rdy  = 1'b1;
    lim[1]   = 2;
    lim[0]   = 4;
    push(1, 0, 2);
    push(0, 0, 4);
    in_valid = 3'b010;
    pat4     = 8'b11001100;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("t4_out_valid_c%0d", c), 128'(out_valid), 128'(pat4[c]));
      if (c == 4) chk("t4_idle_in_rdy", 128'(in_rdy), 128'(0));
      if (c == 5) chk("t4_regrant_in_rdy", 128'(in_rdy), 128'(3'b001));
      step();
      if (c == 0) in_valid[0] = 1'b1;
    end
    drain("t4_drain", 20);
    chk("t4_req1_beats", 128'(cnt[1]), 128'(2));

    // Reset after the second beat.
    do_reset();
    out_rdy  = 1'b1;
    push(0, 0, 2);
    in_valid = 3'b111;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_out_valid", 128'(out_valid), 128'(0));
    chk("t5_in_rdy", 128'(in_rdy), 128'(0));
    chk("t5_out_src_id", 128'(out_src_id), 128'(0));
    chk("t5_queue_empty", 128'(q.size()), 128'(0));
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt[i] = 0;
      lim[i] = 4;
    end
    drive_data();
    in_valid = 3'b111;
    push(0, 0, 4);
    push(1, 0, 4);
    push(2, 0, 4);
    drain("t5_drain", 60);

    // req0 with 12 beats against req1 with 4.
    do_reset();
    out_rdy  = 1'b1;
    lim[0]   = 12;
    lim[1]   = 4;
`ifdef AES_STREAM_ARB_FIXED_PRIO_EN
    push(0, 0, 12);
    push(1, 0, 4);
`else
    push(0, 0, 4);
    push(1, 0, 4);
    push(0, 4, 8);
`endif
    in_valid = 3'b011;
    drain("t6_drain", 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
